// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, PC width and reset vector.
// Used by the fetch unit, decoder and ALU.
package cpu_pkg;

  localparam int PC_W = 12;
  localparam logic [PC_W-1:0] RESET_VECTOR = 12'h000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_EXEC   = 3'd1,
    ST_HALT   = 3'd2,
    ST_STEP_F = 3'd3,
    ST_STEP_E = 3'd4
  } state_t;

  function automatic logic is_fetch(input state_t s);
    return (s == ST_FETCH) || (s == ST_STEP_F);
  endfunction

  function automatic logic is_exec(input state_t s);
    return (s == ST_EXEC) || (s == ST_STEP_E);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: run/step control, decoder PC requests, ROM data in,
// and the PC/instruction/phase outputs consumed by the decoder.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic            Run;
  logic            Step;
  logic            IncPC;
  logic            LoadPC;
  logic [7:0]      RomData;
  logic [PC_W-1:0] PC;
  logic            Phase;
  logic [3:0]      Instr;
  logic [3:0]      Oprnd;
  logic [PC_W-1:0] Addr;
  logic            CpuEn;
  logic            Halted;

  modport master (
    output Run, Step, IncPC, LoadPC, RomData,
    input  PC, Phase, Instr, Oprnd, Addr, CpuEn, Halted
  );

  modport slave (
    input  Run, Step, IncPC, LoadPC, RomData,
    output PC, Phase, Instr, Oprnd, Addr, CpuEn, Halted
  );
endinterface

// File: rtl/pc_reg.sv
// Program counter with load > increment > hold priority; increments wrap
// modulo 2^PC_W.
module pc_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  // Next-PC mux: a jump overrides a simultaneous increment.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + 12'd1;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Two-phase fetch/execute sequencer with run/halt/single-step control and
// the instruction register; the PC lives in pc_reg.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  fetch_unit_if.slave  bus
);

  state_t     state_d, state_q;
  logic [3:0] instr_d, instr_q;
  logic [3:0] oprnd_d, oprnd_q;
  logic       step_d, step_q;
  logic       phase_d, phase_q;
  logic       cpu_en_d, cpu_en_q;
  logic       halted_d, halted_q;
  logic       step_rise;
  logic       pc_inc;
  logic       pc_load;

  // Next-state, instruction register and PC request decode.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    oprnd_d   = oprnd_q;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    step_rise = bus.Step & ~step_q;
    case (state_q)
      ST_FETCH, ST_STEP_F: begin
        {instr_d, oprnd_d} = bus.RomData;
        pc_inc  = bus.IncPC;
        state_d = (state_q == ST_FETCH) ? ST_EXEC : ST_STEP_E;
      end
      ST_EXEC: begin
        pc_load = bus.LoadPC;
        pc_inc  = bus.IncPC;
        state_d = bus.Run ? ST_FETCH : ST_HALT;
      end
      ST_STEP_E: begin
        pc_load = bus.LoadPC;
        pc_inc  = bus.IncPC;
        state_d = ST_HALT;
      end
      ST_HALT: begin
        if (bus.Run) begin
          state_d = ST_FETCH;
        end else if (step_rise) begin
          state_d = ST_STEP_F;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
    // Status outputs are registered from the next state so they are glitch-free.
    step_d   = bus.Step;
    phase_d  = is_exec(state_d);
    cpu_en_d = (state_d != ST_HALT);
    halted_d = (state_d == ST_HALT);
  end

  // State, instruction register and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_HALT;
      instr_q  <= 4'h0;
      oprnd_q  <= 4'h0;
      step_q   <= 1'b1;
      phase_q  <= 1'b0;
      cpu_en_q <= 1'b0;
      halted_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      oprnd_q  <= oprnd_d;
      step_q   <= step_d;
      phase_q  <= phase_d;
      cpu_en_q <= cpu_en_d;
      halted_q <= halted_d;
    end
  end

  pc_reg u_pc_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val ({oprnd_q, bus.RomData}),
    .pc       (bus.PC)
  );

  assign bus.Phase  = phase_q;
  assign bus.Instr  = instr_q;
  assign bus.Oprnd  = oprnd_q;
  assign bus.Addr   = {oprnd_q, bus.RomData};
  assign bus.CpuEn  = cpu_en_q;
  assign bus.Halted = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit: a table of per-cycle inputs and
// expected outputs, plus hand sequences for reset behaviour.
module tb_fetch_unit;
  import cpu_pkg::*;

  typedef struct {
    logic        run;
    logic        step;
    logic        inc;
    logic        load;
    logic [11:0] pc;
    logic        phase;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        cpuen;
    logic        halted;
    logic [11:0] addr;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] rom [0:4095];
  vec_t       vecs [$];
  int         n_vec;
  int         n_err;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.RomData = rom[bus.PC];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic run, input logic step, input logic inc,
                              input logic load, input logic [11:0] pc, input logic phase,
                              input logic [3:0] instr, input logic [3:0] oprnd,
                              input logic cpuen, input logic halted, input logic [11:0] addr);
    vec_t v;
    v.run = run; v.step = step; v.inc = inc; v.load = load;
    v.pc = pc; v.phase = phase; v.instr = instr; v.oprnd = oprnd;
    v.cpuen = cpuen; v.halted = halted; v.addr = addr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    n_vec++;
    chk({tag, " PC"},     bus.PC,              v.pc);
    chk({tag, " Phase"},  {11'd0, bus.Phase},  {11'd0, v.phase});
    chk({tag, " Instr"},  {8'd0, bus.Instr},   {8'd0, v.instr});
    chk({tag, " Oprnd"},  {8'd0, bus.Oprnd},   {8'd0, v.oprnd});
    chk({tag, " CpuEn"},  {11'd0, bus.CpuEn},  {11'd0, v.cpuen});
    chk({tag, " Halted"}, {11'd0, bus.Halted}, {11'd0, v.halted});
    chk({tag, " Addr"},   bus.Addr,            v.addr);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h4A; rom[12'h001] = 8'hC0; rom[12'h002] = 8'h05;
    rom[12'h005] = 8'hC3; rom[12'h006] = 8'h21; rom[12'h321] = 8'h50;
    rom[12'h322] = 8'hA7; rom[12'h0A9] = 8'h7E; rom[12'h0AB] = 8'hCF;
    rom[12'h0AC] = 8'hFF; rom[12'hFFF] = 8'h11;

    // run step inc load | pc phase instr oprnd cpuen halted addr
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0, 12'h000,1'b0,4'h0,4'h0,1'b1,1'b0,12'h04A));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0, 12'h001,1'b1,4'h4,4'hA,1'b1,1'b0,12'hAC0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0, 12'h001,1'b0,4'h4,4'hA,1'b1,1'b0,12'hAC0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0, 12'h002,1'b1,4'hC,4'h0,1'b1,1'b0,12'h005));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1, 12'h005,1'b0,4'hC,4'h0,1'b1,1'b0,12'h0C3));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0, 12'h006,1'b1,4'hC,4'h3,1'b1,1'b0,12'h321));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1, 12'h321,1'b0,4'hC,4'h3,1'b1,1'b0,12'h350));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0, 12'h322,1'b1,4'h5,4'h0,1'b1,1'b0,12'h0A7));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b1, 12'h0A7,1'b0,4'h5,4'h0,1'b1,1'b0,12'h000));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0, 12'h0A8,1'b1,4'h0,4'h0,1'b1,1'b0,12'h000));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0, 12'h0A9,1'b0,4'h0,4'h0,1'b0,1'b1,12'h07E));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1, 12'h0A9,1'b0,4'h0,4'h0,1'b0,1'b1,12'h07E));
    vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 12'h0A9,1'b0,4'h0,4'h0,1'b1,1'b0,12'h07E));
    vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 12'h0AA,1'b1,4'h7,4'hE,1'b1,1'b0,12'hE00));
    vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 12'h0AB,1'b0,4'h7,4'hE,1'b0,1'b1,12'hECF));
    vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 12'h0AB,1'b0,4'h7,4'hE,1'b0,1'b1,12'hECF));
    vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0, 12'h0AB,1'b0,4'h7,4'hE,1'b0,1'b1,12'hECF));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0, 12'h0AB,1'b0,4'h7,4'hE,1'b0,1'b1,12'hECF));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0, 12'h0AB,1'b0,4'h7,4'hE,1'b1,1'b0,12'hECF));
    vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0, 12'h0AB,1'b1,4'hC,4'hF,1'b1,1'b0,12'hFCF));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0, 12'h0AB,1'b0,4'hC,4'hF,1'b0,1'b1,12'hFCF));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0, 12'h0AB,1'b0,4'hC,4'hF,1'b1,1'b0,12'hFCF));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0, 12'h0AC,1'b1,4'hC,4'hF,1'b1,1'b0,12'hFFF));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1, 12'hFFF,1'b0,4'hC,4'hF,1'b1,1'b0,12'hF11));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0, 12'h000,1'b1,4'h1,4'h1,1'b1,1'b0,12'h14A));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0, 12'h001,1'b0,4'h1,4'h1,1'b1,1'b0,12'h1C0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0, 12'h002,1'b1,4'hC,4'h0,1'b1,1'b0,12'h005));

    // Reset held low: everything cleared, no enable.
    reset_n    = 1'b0;
    bus.Run    = 1'b1;
    bus.Step   = 1'b0;
    bus.IncPC  = 1'b0;
    bus.LoadPC = 1'b0;
    #12;
    n_vec++;
    chk("reset PC",    bus.PC,              12'h000);
    chk("reset Phase", {11'd0, bus.Phase},  12'h000);
    chk("reset Instr", {8'd0, bus.Instr},   12'h000);
    chk("reset Oprnd", {8'd0, bus.Oprnd},   12'h000);
    chk("reset CpuEn", {11'd0, bus.CpuEn},  12'h000);
    #1 reset_n = 1'b1;

    foreach (vecs[i]) begin
      bus.Run    = vecs[i].run;
      bus.Step   = vecs[i].step;
      bus.IncPC  = vecs[i].inc;
      bus.LoadPC = vecs[i].load;
      @(posedge clk);
      #1;
      check_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Reset in EXEC with a pending load: PC clears at once and the load is lost.
    bus.IncPC  = 1'b0;
    bus.LoadPC = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    chk("async PC",    bus.PC,             12'h000);
    chk("async Phase", {11'd0, bus.Phase}, 12'h000);
    chk("async CpuEn", {11'd0, bus.CpuEn}, 12'h000);
    chk("async Instr", {8'd0, bus.Instr},  12'h000);
    @(posedge clk);
    #1;
    n_vec++;
    chk("held PC",     bus.PC,             12'h000);
    chk("held CpuEn",  {11'd0, bus.CpuEn}, 12'h000);
    bus.Run = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    chk("post-rst Halted", {11'd0, bus.Halted}, 12'h001);
    chk("post-rst CpuEn",  {11'd0, bus.CpuEn},  12'h000);
    chk("post-rst PC",     bus.PC,              12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Run, input, 1, free-run enable.
REQ-004 SHALL have port Step, input, 1, single-instruction request, level-sampled.
REQ-005 SHALL have port IncPC, input, 1, PC increment request from the decoder.
REQ-006 SHALL have port LoadPC, input, 1, PC load request from the decoder.
REQ-007 SHALL have port RomData, input, 8, program ROM byte at address PC, combinational.
REQ-008 SHALL have port PC, output, 12, program ROM address.
REQ-009 SHALL have port Phase, output, 1, 0 = fetch cycle, 1 = execute cycle; goes to the decoder.
REQ-010 SHALL have port Instr, output, 4, registered opcode nibble.
REQ-011 SHALL have port Oprnd, output, 4, registered operand nibble.
REQ-012 SHALL have port Addr, output, 12, {Oprnd, RomData}: jump target / RAM address in execute.
REQ-013 SHALL have port CpuEn, output, 1, high when the current cycle's decoder outputs are valid; downstream gates all loads/writes with it.
REQ-014 SHALL have port Halted, output, 1, high in HALT state.

Function
REQ-015 SHALL implement FSM states FETCH, EXEC, HALT, STEP_F, STEP_E.
REQ-016 FETCH SHALL drive Phase=0 and CpuEn=1; at the edge: {Instr,Oprnd} <= RomData; PC <= PC+1 if IncPC; next state EXEC.
REQ-017 EXEC SHALL drive Phase=1 and CpuEn=1; at the edge: if LoadPC, PC <= {Oprnd,RomData}; else if IncPC, PC <= PC+1; else PC holds.
REQ-018 When LoadPC and IncPC are both high, LoadPC SHALL win.
REQ-019 From EXEC: next = FETCH if Run=1, else HALT; an instruction is never split by a halt.
REQ-020 HALT SHALL drive Phase=0, CpuEn=0, Halted=1; PC, Instr and Oprnd hold; IncPC and LoadPC are ignored.
REQ-021 From HALT: Run=1 -> FETCH; Run=0 and Step=1 -> STEP_F; Run has priority over Step.
REQ-022 STEP_F SHALL behave as FETCH and STEP_E as EXEC; STEP_E always returns to HALT, regardless of Run.
REQ-023 Step SHALL be rising-edge detected internally; a held-high Step yields exactly one instruction.
REQ-024 PC arithmetic SHALL be 12-bit modulo: 0xFFF+1 = 0x000, with no flag.
REQ-025 Addr SHALL be combinational from Oprnd and RomData in every state.
REQ-026 Phase SHALL be a registered state decode, glitch-free.

Reset
REQ-027 reset_n low SHALL immediately force PC=0x000, Instr=0x0, Oprnd=0x0, Phase=0, step-edge register=1.
REQ-028 The state after reset SHALL be FETCH if Run=1 at the first edge after release, else HALT; CpuEn=0 while reset_n is low.
REQ-029 Reset asserted mid-instruction (EXEC) SHALL abort it with no PC update.

Structure
REQ-030 State encoding, PC width (12) and reset vector SHALL live in the shared package cpu_pkg, used also by the decoder and ALU.
REQ-031 The PC register with its inc/load/hold mux SHALL be the sub-module pc_reg; FSM and instruction register stay in fetch_unit.

Verification
REQ-032 Reset with Run=1, ROM[0]=0x4A (LIT), decoder IncPC=1/0 -> PC 0->1, Instr=4, Oprnd=A, Phase toggles 0,1,0.
REQ-033 JMP: ROM[5]=0xC3, ROM[6]=0x21 -> after the EXEC edge PC=0x321.
REQ-034 Wrap: PC=0xFFF in FETCH with IncPC=1 -> PC=0x000.
REQ-035 Run=0 during EXEC -> completes EXEC, Halted=1, PC frozen for 10 cycles; a Step pulse held 5 cycles -> exactly one FETCH+EXEC, then HALT.
REQ-036 reset_n asserted in EXEC with LoadPC=1 -> PC=0x000 asynchronously, no load.
REQ-037 LoadPC=IncPC=1 in EXEC with Addr=0x0A7 -> PC=0x0A7.
